// File: rtl/sort4_sequencer.sv
// sort4_sequencer: sorts four W-bit keys ascending by stepping one compare-and-swap
// unit through a fixed six-step bubble network, reporting the swap count.
module sort4_sequencer #(
  parameter int W = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [4*W-1:0] in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [4*W-1:0] out_data,
  output logic [2:0]     swaps,
  output logic           busy
);
  typedef enum logic [1:0] {IDLE, SORT, DONE} state_t;
  state_t r_state, w_next;
  logic [W-1:0] r_k [4];
  logic [2:0] r_step, r_swaps;
  logic [1:0] w_li, w_ri;
  logic w_gt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_comb
    w_next = (r_state == IDLE && in_valid)       ? SORT :
             (r_state == SORT && r_step == 3'd5) ? DONE :
             (r_state == DONE && out_ready)      ? IDLE : r_state;
  always_comb begin
    in_ready  = r_state == IDLE;
    out_valid = r_state == DONE;
    busy      = r_state != IDLE;
    out_data  = {r_k[0], r_k[1], r_k[2], r_k[3]};
    swaps     = r_swaps;
  end
  // Step pairs: 0,3,5 -> (r0,r1); 1,4 -> (r1,r2); 2 -> (r2,r3)
  always_comb begin
    w_li = (r_step == 3'd1 || r_step == 3'd4) ? 2'd1 : (r_step == 3'd2) ? 2'd2 : 2'd0;
    w_ri = w_li + 2'd1;
    w_gt = r_k[w_li] > r_k[w_ri];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_k     <= '{default: '0};
      r_step  <= '0;
      r_swaps <= '0;
    end else if (r_state == IDLE && in_valid) begin
      r_k[0]  <= in_data[4*W-1:3*W];
      r_k[1]  <= in_data[3*W-1:2*W];
      r_k[2]  <= in_data[2*W-1:W];
      r_k[3]  <= in_data[W-1:0];
      r_step  <= '0;
      r_swaps <= '0;
    end else if (r_state == SORT) begin
      r_step <= r_step + 3'd1;
      if (w_gt) begin
        r_k[w_li] <= r_k[w_ri];
        r_k[w_ri] <= r_k[w_li];
        r_swaps   <= r_swaps + 3'd1;
      end
    end
endmodule

// File: tb/tb_sort4_sequencer.sv
// tb_sort4_sequencer: directed and exhaustive checks of sort4_sequencer against a
// timing/result model built from a plain sort plus inversion count.
module tb_sort4_sequencer;
  localparam int W = 2;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 1;
  logic [4*W-1:0] in_data = '0;
  logic in_ready, out_valid, busy;
  logic [4*W-1:0] out_data;
  logic [2:0] swaps;
  int checks = 0, failures = 0;
  bit sp_en = 0;
  bit m_busy = 0;
  int m_cnt = 0, cyc = 0, last_cap = -1;
  logic [4*W-1:0] m_d = '0;
  logic [2:0] m_s = '0;

  sort4_sequencer #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .swaps(swaps), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [10:0] fn_ref(input logic [7:0] d);
    int k[4];
    int t, inv;
    inv = 0;
    for (int i = 0; i < 4; i++) k[i] = int'(d[7-2*i -: 2]);
    for (int i = 0; i < 4; i++)
      for (int j = i + 1; j < 4; j++)
        if (k[i] > k[j]) inv++;
    for (int i = 0; i < 4; i++)
      for (int j = i + 1; j < 4; j++)
        if (k[j] < k[i]) begin t = k[i]; k[i] = k[j]; k[j] = t; end
    return {k[0][1:0], k[1][1:0], k[2][1:0], k[3][1:0], inv[2:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_busy <= 0;
      m_cnt  <= 0;
    end else begin
      cyc <= cyc + 1;
      if (!sp_en) last_cap <= -1;
      if (!m_busy) begin
        if (in_valid) begin
          m_busy <= 1;
          m_cnt  <= 0;
          {m_d, m_s} <= fn_ref(in_data);
          if (sp_en) begin
            if (last_cap >= 0) check("capture_spacing", cyc - last_cap, 8);
            last_cap <= cyc;
          end
        end
      end else if (m_cnt < 6) m_cnt <= m_cnt + 1;
      else if (out_ready) m_busy <= 0;
    end

  always @(negedge clk) begin
    check("in_ready", in_ready, !m_busy);
    check("out_valid", out_valid, m_busy && m_cnt == 6);
    check("busy", busy, m_busy);
    if (m_busy && m_cnt == 6) begin
      check("out_data", out_data, m_d);
      check("swaps", swaps, m_s);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin tick(); n++; end
    check({name, "_ready_timeout"}, in_ready, 1);
  endtask

  task automatic run_word(input string name, input logic [7:0] d, input logic [7:0] ed, input logic [2:0] es);
    wait_ready(name);
    in_valid = 1;
    in_data = d;
    tick();
    in_valid = 0;
    in_data = ~d;
    repeat (5) tick();
    check({name, "_early"}, out_valid, 0);
    tick();
    check({name, "_valid"}, out_valid, 1);
    check({name, "_data"}, out_data, ed);
    check({name, "_swaps"}, swaps, es);
    tick();
    check({name, "_idle"}, in_ready, 1);
  endtask

  initial begin
    check("ref_E4", fn_ref(8'hE4), {8'h1B, 3'd6});
    check("ref_1B", fn_ref(8'h1B), {8'h1B, 3'd0});
    check("ref_A2", fn_ref(8'hA2), {8'h2A, 3'd2});
    check("ref_4E", fn_ref(8'h4E), {8'h1B, 3'd2});
    #2;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_data", out_data, 0);
    check("rst_swaps", swaps, 0);
    tick(); tick();
    rst_n = 1;
    tick();
    run_word("reverse", 8'hE4, 8'h1B, 3'd6);
    run_word("sorted", 8'h1B, 8'h1B, 3'd0);
    out_ready = 0;
    wait_ready("ties");
    in_valid = 1;
    in_data = 8'hA2;
    tick();
    in_valid = 0;
    repeat (6) tick();
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      in_data = 8'hE4;
      tick();
      check("bp_ready", in_ready, 0);
      check("bp_data", out_data, 8'h2A);
      check("bp_swaps", swaps, 3'd2);
    end
    in_valid = 0;
    out_ready = 1;
    tick();
    check("bp_release_ready", in_ready, 1);
    check("bp_release_valid", out_valid, 0);
    tick();
    check("bp_no_capture", busy, 0);
    wait_ready("midrst");
    in_valid = 1;
    in_data = 8'hE4;
    tick();
    in_valid = 0;
    repeat (3) tick();
    rst_n = 0;
    #1;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_busy", busy, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_swaps", swaps, 0);
    tick();
    rst_n = 1;
    tick();
    run_word("after_rst", 8'h4E, 8'h1B, 3'd2);
    sp_en = 1;
    in_valid = 1;
    for (int v = 0; v < 256; v++) begin
      wait_ready("exh");
      in_data = v[7:0];
      tick();
    end
    in_valid = 0;
    repeat (10) tick();
    check("final_idle", in_ready, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
